// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver
//
// Recovers frames of: start bit (0), DATA_WIDTH data bits LSB-first, an
// optional parity bit, and one stop bit (1). The line is oversampled at
// PRESCALE clocks per bit; each bit is decided by a 2-of-3 majority vote of
// samples taken around the bit centre.
//
// Parity convention: expected parity bit = XOR of PAR_TYP and the data bits,
// so PAR_TYP=0 selects even parity and PAR_TYP=1 selects odd parity.
//
// Ports:
//   CLK        in   clock, all logic on the rising edge
//   RST        in   synchronous active-high reset
//   RX_IN      in   serial line, asynchronous to CLK, idles high
//   PAR_EN     in   1 = frame carries a parity bit
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   P_DATA     out  last received word (updated on every completed frame)
//   DATA_VALID out  one-cycle strobe, good frame on P_DATA
//   PAR_ERR    out  one-cycle strobe, parity mismatch
//   STP_ERR    out  one-cycle strobe, stop bit sampled 0
//   Busy       out  high while a frame is being received (START..STOP)
//
// Parameters:
//   DATA_WIDTH  data bits per frame (>= 1)
//   PRESCALE    CLK cycles per bit; must be even and >= 6
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  Busy
);

  // ---------------------------------------------------------------------------
  // Widths and edge-count landmarks
  // ---------------------------------------------------------------------------
  localparam int ECW = $clog2(PRESCALE);
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Three samples straddle the bit centre; the third one is not stored, it is
  // voted directly from the synchronised line in the resolve cycle.
  localparam logic [ECW-1:0] EDGE_S0   = ECW'(PRESCALE / 2 - 1);
  localparam logic [ECW-1:0] EDGE_S1   = ECW'(PRESCALE / 2);
  localparam logic [ECW-1:0] EDGE_RES  = ECW'(PRESCALE / 2 + 1);
  localparam logic [ECW-1:0] EDGE_LAST = ECW'(PRESCALE - 1);
  localparam logic [ECW-1:0] EDGE_ONE  = ECW'(1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_WIDTH - 1);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ECW-1:0]        edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bad_q, par_bad_d;

  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [1:0]            samp_q;
  logic                  maj;
  logic                  resolve;
  logic                  frame_done;
  logic [DATA_WIDTH-1:0] shift_in;

  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Resets to the idle (high) line level so that a
  // reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX_IN};
    end
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------------------
  // Centre samples. edge_cnt is held at 0 in IDLE and EDGE_S0 >= 2, so these
  // only ever capture inside a frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      samp_q <= 2'b11;
    end else begin
      if (edge_cnt_q == EDGE_S0) begin
        samp_q[0] <= rx_s;
      end
      if (edge_cnt_q == EDGE_S1) begin
        samp_q[1] <= rx_s;
      end
    end
  end

  // 2-of-3 majority; only meaningful in the resolve cycle.
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign resolve = (edge_cnt_q == EDGE_RES);

  // Data arrives LSB first and is shifted in from the MSB side, so after
  // DATA_WIDTH shifts the first received bit sits at bit 0.
  if (DATA_WIDTH == 1) begin : g_shift_one
    assign shift_in = maj;
  end else begin : g_shift_many
    assign shift_in = {maj, shift_q[DATA_WIDTH-1:1]};
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    frame_done = 1'b0;

    // Free-running bit timer while inside a frame.
    if (state_q != IDLE) begin
      edge_cnt_d = (edge_cnt_q == EDGE_LAST) ? '0 : edge_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s) begin
          // The detect cycle itself is edge 0 of the start bit.
          state_d    = START;
          edge_cnt_d = EDGE_ONE;
          par_bad_d  = 1'b0;
        end
      end

      START: begin
        if (resolve && maj) begin
          // Line was low too briefly to be a real start bit.
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (edge_cnt_q == EDGE_LAST) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        if (resolve) begin
          shift_d = shift_in;
        end
        if (edge_cnt_q == EDGE_LAST) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = PAR_EN ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (resolve) begin
          par_bad_d = (maj != (^{PAR_TYP, shift_q}));
        end
        if (edge_cnt_q == EDGE_LAST) begin
          state_d = STOP;
        end
      end

      STOP: begin
        // Leave at the bit centre rather than the bit end so a start bit that
        // immediately follows the stop bit is still caught on its first edge.
        if (resolve) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
          frame_done = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output strobes: registered in the STOP resolve cycle, so they appear on
  // the first IDLE cycle and last exactly one clock. P_DATA is written on
  // errored frames too, so a controller can inspect what was received.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      if (frame_done) begin
        p_data_q     <= shift_q;
        stp_err_q    <= ~maj;
        par_err_q    <= PAR_EN & par_bad_q;
        data_valid_q <= maj & ~(PAR_EN & par_bad_q);
      end
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed, scoreboard-based bench for uart_rx
//
// Frames are driven bit by bit on RX_IN; each frame pushes its expected
// result (word, error flags, optional exact strobe cycle) to a queue, and a
// monitor pops and compares whenever the DUT raises any strobe.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int DW = 8;
  localparam int PS = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;
  logic          Busy;

  uart_rx #(
    .DATA_WIDTH(DW),
    .PRESCALE  (PS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  // Count of rising edges so far; stable when read at the falling edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          par_err;
    logic          stp_err;
    int            exp_cyc;   // -1 = strobe timing not checked
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   n_strobes = 0;
  logic width_pending = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard pop
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    if (width_pending) begin
      chk("strobe_width", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
    end
    width_pending = 1'b0;
    if (!RST && (DATA_VALID || PAR_ERR || STP_ERR)) begin
      n_strobes++;
      width_pending = 1'b1;
      chk("strobe_expected", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        $display("frame %0d @cyc %0d: P_DATA=%02h DV=%0b PE=%0b SE=%0b (exp %02h PE=%0b SE=%0b)",
                 n_strobes, cyc, P_DATA, DATA_VALID, PAR_ERR, STP_ERR,
                 mon_e.data, mon_e.par_err, mon_e.stp_err);
        chk("p_data",     P_DATA,     mon_e.data);
        chk("par_err",    PAR_ERR,    mon_e.par_err);
        chk("stp_err",    STP_ERR,    mon_e.stp_err);
        chk("data_valid", DATA_VALID, !(mon_e.par_err || mon_e.stp_err));
        chk("busy_at_strobe", Busy, 0);
        if (mon_e.exp_cyc >= 0) begin
          chk("strobe_cycle", cyc, mon_e.exp_cyc);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all leave the caller 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (cyc < target && k < 1000);
  endtask

  // One bit time; with glitch set the line is inverted for the single cycle
  // that the receiver sees at edge_cnt = PS/2.
  task automatic drive_bit(input logic val, input logic glitch);
    RX_IN = val;
    if (glitch) begin
      tick(PS / 2);
      RX_IN = ~val;
      tick(1);
      RX_IN = val;
      tick(PS / 2 - 1);
    end else begin
      tick(PS);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic pen, input logic ptyp,
                            input logic flip_par, input logic stop_bit,
                            input logic glitch, input logic chk_lat);
    exp_t e;
    logic pbit;
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    pbit = (^{ptyp, data}) ^ flip_par;
    e.data    = data;
    e.par_err = pen & flip_par;
    e.stp_err = ~stop_bit;
    // 78 cycles from the first low synchronised sample (no parity) plus the
    // two synchronizer stages between RX_IN and rx_s.
    e.exp_cyc = chk_lat ? (cyc + PS * (1 + DW + int'(pen)) + PS / 2 + 2 + 2) : -1;
    sb_q.push_back(e);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < DW; i++) begin
      drive_bit(data[i], glitch);
    end
    if (pen) begin
      drive_bit(pbit, 1'b0);
    end
    drive_bit(stop_bit, 1'b0);
    RX_IN = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int t0;

  initial begin
    RST     = 1'b1;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    tick(3);
    @(negedge CLK);
    chk("rst_p_data",     P_DATA,     0);
    chk("rst_data_valid", DATA_VALID, 0);
    chk("rst_par_err",    PAR_ERR,    0);
    chk("rst_stp_err",    STP_ERR,    0);
    chk("rst_busy",       Busy,       0);
    tick(1);
    RST = 1'b0;
    tick(2 * PS);

    // Plain frame, strobe timing checked.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(2 * PS);

    // Parity: even ok, odd ok, flipped parity bit.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2 * PS);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2 * PS);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(2 * PS);

    // Stop bit low, then recovery.
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2 * PS);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2 * PS);

    // Two-cycle low pulse while idle: rejected as a glitch.
    RX_IN = 1'b0;
    t0 = cyc;
    tick(2);
    RX_IN = 1'b1;
    wait_cyc(t0 + 4);
    chk("glitch_busy_start", Busy, 1);
    wait_cyc(t0 + 8);
    chk("glitch_busy_released", Busy, 0);
    tick(2 * PS);

    // Mid-bit single-cycle glitches outvoted.
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(2 * PS);

    // Reset during data bit 4; the aborted frame must produce no strobe.
    PAR_EN = 1'b0;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1, 1'b0);
    end
    RX_IN = 1'b1;
    tick(3);
    RST = 1'b1;
    tick(1);
    @(negedge CLK);
    chk("midrst_busy",       Busy,       0);
    chk("midrst_data_valid", DATA_VALID, 0);
    chk("midrst_par_err",    PAR_ERR,    0);
    chk("midrst_stp_err",    STP_ERR,    0);
    chk("midrst_p_data",     P_DATA,     0);
    tick(1);
    RST = 1'b0;
    tick(2 * PS);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2 * PS);

    // Back-to-back frames, no idle gap.
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(4 * PS);

    for (int k = 0; k < 500 && sb_q.size() != 0; k++) begin
      @(negedge CLK);
    end
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("strobe_count", n_strobes, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
